// File: rtl/muldiv_unit_if.sv
// Bus between the control FSM and the multiply/divide unit.
// The master side drives requests and mthi/mtlo writes; the slave side is the unit itself.
interface muldiv_unit_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             hi_wr;
  logic             lo_wr;
  logic [WIDTH-1:0] wr_data;
  logic             abort;
  logic [WIDTH-1:0] hi_out;
  logic [WIDTH-1:0] lo_out;
  logic             busy;
  logic             done;
  logic             div_by_zero;

  modport master (
    output start, op, a, b, hi_wr, lo_wr, wr_data, abort,
    input  hi_out, lo_out, busy, done, div_by_zero
  );

  modport slave (
    input  start, op, a, b, hi_wr, lo_wr, wr_data, abort,
    output hi_out, lo_out, busy, done, div_by_zero
  );
endinterface

// File: rtl/muldiv_unit.sv
// Sequential multiply/divide unit with integrated HI/LO registers.
// op: 00 mult, 01 multu, 10 div, 11 divu. One iteration per cycle on sign-stripped magnitudes,
// sign correction and HI/LO write in a final FIX cycle.
// Optional feature: define MULDIV_ABORT_EN to let abort cancel a running operation.
module muldiv_unit #(
  parameter int unsigned WIDTH = 32
) (
  input logic          clk,
  input logic          reset,
  muldiv_unit_if.slave bus
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {StIdle, StRun, StFix} state_e;

  state_e             state_q, state_d;
  logic [1:0]         op_q, op_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;     // mult: {partial, multiplier}; div: {remainder, quotient}
  logic [WIDTH-1:0]   mcand_q, mcand_d; // multiplicand or divisor magnitude
  logic               neg_lo_q, neg_lo_d;
  logic               neg_hi_q, neg_hi_d;
  logic               zero_q, zero_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;
  logic               dbz_q, dbz_d;

  logic               sign_a, sign_b;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_trial;
  logic [2*WIDTH-1:0] mul_next, div_next, prod;
  logic [WIDTH-1:0]   quot, rem;

  // Operand sign stripping and one iteration of each datapath.
  always_comb begin
    sign_a    = bus.a[WIDTH-1] & ~bus.op[0];
    sign_b    = bus.b[WIDTH-1] & ~bus.op[0];
    mag_a     = sign_a ? (~bus.a + 1'b1) : bus.a;
    mag_b     = sign_b ? (~bus.b + 1'b1) : bus.b;
    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
    mul_next  = {mul_sum, acc_q[WIDTH-1:1]};
    div_trial = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]} - {1'b0, mcand_q};
    // Restore (keep the shifted remainder) when the trial subtraction goes negative.
    div_next  = div_trial[WIDTH] ? {acc_q[2*WIDTH-2:0], 1'b0}
                                 : {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    prod      = neg_lo_q ? (~acc_q + 1'b1) : acc_q;
    quot      = neg_lo_q ? (~acc_q[WIDTH-1:0] + 1'b1) : acc_q[WIDTH-1:0];
    rem       = neg_hi_q ? (~acc_q[2*WIDTH-1:WIDTH] + 1'b1) : acc_q[2*WIDTH-1:WIDTH];
  end

  // Next-state, datapath load and HI/LO write control.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    neg_lo_d = neg_lo_q;
    neg_hi_d = neg_hi_q;
    zero_d   = zero_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    dbz_d    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.hi_wr) hi_d = bus.wr_data;
        if (bus.lo_wr) lo_d = bus.wr_data;
        if (bus.start) begin
          op_d     = bus.op;
          neg_lo_d = sign_a ^ sign_b;
          neg_hi_d = sign_a;
          zero_d   = bus.op[1] && (bus.b == '0);
          if (bus.op[1]) begin
            acc_d   = {{WIDTH{1'b0}}, mag_a};
            mcand_d = mag_b;
          end else begin
            acc_d   = {{WIDTH{1'b0}}, mag_b};
            mcand_d = mag_a;
          end
          if (bus.op[1] && (bus.b == '0)) begin
            cnt_d   = '0;
            state_d = StFix;
          end else begin
            cnt_d   = CntW'(WIDTH);
            state_d = StRun;
          end
        end
      end
      StRun: begin
        acc_d = op_q[1] ? div_next : mul_next;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CntW'(1)) state_d = StFix;
      end
      StFix: begin
        state_d = StIdle;
        done_d  = 1'b1;
        if (zero_q) begin
          dbz_d = 1'b1;
        end else if (op_q[1]) begin
          hi_d = rem;
          lo_d = quot;
        end else begin
          hi_d = prod[2*WIDTH-1:WIDTH];
          lo_d = prod[WIDTH-1:0];
        end
      end
      default: state_d = StIdle;
    endcase

`ifdef MULDIV_ABORT_EN
    // Flush: drop the partial result without touching HI/LO or pulsing done.
    if ((state_q != StIdle) && bus.abort) begin
      state_d = StIdle;
      cnt_d   = '0;
      hi_d    = hi_q;
      lo_d    = lo_q;
      done_d  = 1'b0;
      dbz_d   = 1'b0;
    end
`endif
  end

`ifndef MULDIV_ABORT_EN
  logic unused_abort;
  assign unused_abort = bus.abort;
`endif

  // State and result registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      op_q     <= '0;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      zero_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
      dbz_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      neg_lo_q <= neg_lo_d;
      neg_hi_q <= neg_hi_d;
      zero_q   <= zero_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
      dbz_q    <= dbz_d;
    end
  end

  assign bus.hi_out      = hi_q;
  assign bus.lo_out      = lo_q;
  assign bus.busy        = (state_q != StIdle);
  assign bus.done        = done_q;
  assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: a cycle-level behavioural model of the 32-bit unit is
// compared on every falling edge; directed literal checks pin the model; a small 8-bit
// instance covers the WIDTH generalisation and, when MULDIV_ABORT_EN is defined, abort.
module tb_muldiv_unit;

  localparam int W = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  muldiv_unit_if #(.WIDTH(32)) bus ();
  muldiv_unit_if #(.WIDTH(8))  bus8 ();

  muldiv_unit #(.WIDTH(32)) dut (.clk(clk), .reset(rst_n), .bus(bus));
  muldiv_unit #(.WIDTH(8))  dut8 (.clk(clk), .reset(rst_n), .bus(bus8));

  int n_vec = 0;
  int n_err = 0;
  bit cmp_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference arithmetic straight from the operation definitions.
  function automatic void compute(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] h, output logic [31:0] l, output bit z);
    logic signed [63:0] sa, sb, sp;
    logic [63:0] up;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    z = 1'b0;
    h = '0;
    l = '0;
    case (op)
      2'b00: begin sp = sa * sb; h = sp[63:32]; l = sp[31:0]; end
      2'b01: begin up = {32'b0, a} * {32'b0, b}; h = up[63:32]; l = up[31:0]; end
      2'b10: begin
        if (b == 0) z = 1'b1;
        else begin sp = sa / sb; l = sp[31:0]; sp = sa % sb; h = sp[31:0]; end
      end
      default: begin
        if (b == 0) z = 1'b1;
        else begin l = a / b; h = a % b; end
      end
    endcase
  endfunction

  // Cycle model: a busy countdown of WIDTH+1 (or 1 for divide by zero) cycles.
  logic        m_busy = 1'b0, m_done = 1'b0, m_dbz = 1'b0;
  logic [31:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
  bit          p_zero = 1'b0;
  int          m_left = 0;

  always @(posedge clk or negedge rst_n) begin : model
    logic        nb, nd, nz;
    logic [31:0] nh, nl, rh, rl;
    bit          rz;
    int          left;
    if (!rst_n) begin
      m_busy <= 1'b0; m_done <= 1'b0; m_dbz <= 1'b0;
      m_hi <= '0; m_lo <= '0; m_left <= 0;
    end else begin
      nb = m_busy; nh = m_hi; nl = m_lo; left = m_left;
      rh = p_hi; rl = p_lo; rz = p_zero;
      nd = 1'b0; nz = 1'b0;
      if (!m_busy) begin
        if (bus.hi_wr) nh = bus.wr_data;
        if (bus.lo_wr) nl = bus.wr_data;
        if (bus.start) begin
          compute(bus.op, bus.a, bus.b, rh, rl, rz);
          nb = 1'b1;
          left = rz ? 1 : W + 1;
        end
      end else begin
`ifdef MULDIV_ABORT_EN
        if (bus.abort) nb = 1'b0;
        else
`endif
        begin
          left--;
          if (left == 0) begin
            nb = 1'b0;
            nd = 1'b1;
            if (rz) nz = 1'b1;
            else begin nh = rh; nl = rl; end
          end
        end
      end
      m_busy <= nb; m_done <= nd; m_dbz <= nz;
      m_hi <= nh; m_lo <= nl; m_left <= left;
      p_hi <= rh; p_lo <= rl; p_zero <= rz;
    end
  end

  // Compare every cycle while out of reset.
  always @(negedge clk) begin
    if (rst_n && cmp_en) begin
      check("busy", 64'(bus.busy), 64'(m_busy));
      check("done", 64'(bus.done), 64'(m_done));
      check("div_by_zero", 64'(bus.div_by_zero), 64'(m_dbz));
      check("hi_out", 64'(bus.hi_out), 64'(m_hi));
      check("lo_out", 64'(bus.lo_out), 64'(m_lo));
    end
  end

  // Called on a falling edge; returns on the falling edge where done is visible.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int lat);
    bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
    @(negedge clk);
    bus.start = 1'b0;
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (bus.done) begin lat = k; break; end
    end
  endtask

  function automatic logic [31:0] rand_word();
    case ($urandom % 6)
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'($urandom % 16) - 32'd8;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int lat;
    int ndone;
    bus.start = 0; bus.op = 0; bus.a = 0; bus.b = 0;
    bus.hi_wr = 0; bus.lo_wr = 0; bus.wr_data = 0; bus.abort = 0;
    bus8.start = 0; bus8.op = 0; bus8.a = 0; bus8.b = 0;
    bus8.hi_wr = 0; bus8.lo_wr = 0; bus8.wr_data = 0; bus8.abort = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cmp_en = 1'b1;
    @(negedge clk);
    check("reset busy", 64'(bus.busy), 64'd0);
    check("reset hi", 64'(bus.hi_out), 64'd0);
    check("reset lo", 64'(bus.lo_out), 64'd0);

    run_op(2'b00, 32'hFFFF_FFFD, 32'd7, lat);
    check("mult lat", 64'(lat), 64'd33);
    check("mult hi", 64'(bus.hi_out), 64'hFFFF_FFFF);
    check("mult lo", 64'(bus.lo_out), 64'hFFFF_FFEB);

    run_op(2'b01, 32'hFFFF_FFFF, 32'd2, lat);
    check("multu hi", 64'(bus.hi_out), 64'h1);
    check("multu lo", 64'(bus.lo_out), 64'hFFFF_FFFE);

    run_op(2'b10, 32'hFFFF_FFF9, 32'd2, lat);
    check("div lo", 64'(bus.lo_out), 64'hFFFF_FFFD);
    check("div hi", 64'(bus.hi_out), 64'hFFFF_FFFF);

    run_op(2'b11, 32'd7, 32'd2, lat);
    check("divu lo", 64'(bus.lo_out), 64'd3);
    check("divu hi", 64'(bus.hi_out), 64'd1);

    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, lat);
    check("min/-1 lo", 64'(bus.lo_out), 64'h8000_0000);
    check("min/-1 hi", 64'(bus.hi_out), 64'd0);

    // Preload then divide by zero.
    @(negedge clk);
    bus.hi_wr = 1; bus.wr_data = 32'h1234;
    @(negedge clk);
    bus.hi_wr = 0; bus.lo_wr = 1; bus.wr_data = 32'h5678;
    @(negedge clk);
    bus.lo_wr = 0;
    run_op(2'b10, 32'd5, 32'd0, lat);
    check("dbz lat", 64'(lat), 64'd1);
    check("dbz flag", 64'(bus.div_by_zero), 64'd1);
    check("dbz hi", 64'(bus.hi_out), 64'h1234);
    check("dbz lo", 64'(bus.lo_out), 64'h5678);

    // A start while busy is ignored.
    bus.start = 1; bus.op = 2'b00; bus.a = 32'd5; bus.b = 32'd6;
    @(negedge clk);
    bus.start = 0;
    repeat (4) @(negedge clk);
    bus.start = 1; bus.op = 2'b11; bus.a = 32'd9; bus.b = 32'd2;
    @(negedge clk);
    bus.start = 0;
    lat = -1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus.done) begin lat = k; break; end
    end
    check("ignored start done", 64'(lat >= 0), 64'd1);
    check("ignored start lo", 64'(bus.lo_out), 64'd30);
    check("ignored start hi", 64'(bus.hi_out), 64'd0);

    // Back-to-back: second start issued in the done cycle.
    run_op(2'b01, 32'd100, 32'd200, lat);
    check("b2b first lo", 64'(bus.lo_out), 64'd20000);
    run_op(2'b11, 32'd100, 32'd7, lat);
    check("b2b second lat", 64'(lat), 64'd33);
    check("b2b second lo", 64'(bus.lo_out), 64'd14);
    check("b2b second hi", 64'(bus.hi_out), 64'd2);

    // Asynchronous reset in the middle of a multiply.
    bus.start = 1; bus.op = 2'b00; bus.a = 32'd11; bus.b = 32'd13;
    @(negedge clk);
    bus.start = 0;
    repeat (9) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async rst busy", 64'(bus.busy), 64'd0);
    check("async rst hi", 64'(bus.hi_out), 64'd0);
    check("async rst lo", 64'(bus.lo_out), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done) ndone++;
    end
    check("no done after rst", 64'(ndone), 64'd0);

    // 8-bit instance: signed 0x81 * 0x02.
    bus8.start = 1; bus8.op = 2'b00; bus8.a = 8'h81; bus8.b = 8'h02;
    @(negedge clk);
    bus8.start = 0;
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (bus8.done) begin lat = k; break; end
    end
    check("w8 lat", 64'(lat), 64'd9);
    check("w8 hi", 64'(bus8.hi_out), 64'hFF);
    check("w8 lo", 64'(bus8.lo_out), 64'h02);

`ifdef MULDIV_ABORT_EN
    bus8.start = 1; bus8.op = 2'b01; bus8.a = 8'd3; bus8.b = 8'd5;
    @(negedge clk);
    bus8.start = 0;
    repeat (4) @(negedge clk);
    bus8.abort = 1;
    @(negedge clk);
    bus8.abort = 0;
    check("w8 abort busy", 64'(bus8.busy), 64'd0);
    ndone = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus8.done) ndone++;
    end
    check("w8 abort no done", 64'(ndone), 64'd0);
    check("w8 abort hi", 64'(bus8.hi_out), 64'hFF);
    check("w8 abort lo", 64'(bus8.lo_out), 64'h02);
`endif

    // Random cycle-level stimulus against the model.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      bus.start   = ($urandom % 4) == 0;
      bus.op      = 2'($urandom);
      bus.a       = rand_word();
      bus.b       = (($urandom % 8) == 0) ? 32'd0 : rand_word();
      bus.hi_wr   = ($urandom % 8) == 0;
      bus.lo_wr   = ($urandom % 8) == 0;
      bus.wr_data = $urandom;
      bus.abort   = ($urandom % 64) == 0;
    end
    @(negedge clk);
    bus.start = 0; bus.hi_wr = 0; bus.lo_wr = 0; bus.abort = 0;
    repeat (40) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

- Parametrised sequential multiply/divide unit with integrated HI/LO registers.
- Supersedes the fixed 32-bit signed-only multiplier, divider and HI/LO register trio in the multicycle CPU.
- Adds:
  - WIDTH generalisation
  - unsigned modes
  - mthi/mtlo write ports
  - a single busy/done handshake toward the control FSM
- Sits beside the ALU: fed from registers A/B; HI/LO outputs feed the write-back mux.

## Interface
- WIDTH, 32, operand width; HI and LO are WIDTH bits each; must be ≥ 4.
- clk  input  1  rising-edge clock
- reset  input  1  reset, asynchronous and active-low; clears all state.
- start  input  1  operation request; sampled only in IDLE.
- op  input  2  operation: 00 mult, 01 multu, 10 div, 11 divu
- a  input  WIDTH  multiplicand / dividend
- b  input  WIDTH  multiplier / divisor
- hi_wr  input  1  mthi: load HI from wr_data
- lo_wr  input  1  mtlo: load LO from wr_data
- wr_data  input  WIDTH  data for hi_wr/lo_wr
- abort  input  1  cancel running operation; only functional with MULDIV_ABORT_EN.
- hi_out  output  WIDTH  HI register (product high half / remainder)
- lo_out  output  WIDTH  LO register (product low half / quotient)
- busy  output  1  high in RUN and FIX states
- done  output  1  one-cycle pulse: operation finished, HI/LO valid
- div_by_zero  output  1  one-cycle pulse coincident with done; div/divu with b == 0

## Operation
- States: IDLE, RUN, FIX.
- IDLE with start = 1:
  - Latch op.
  - Latch operand magnitudes: two's-complement absolute value for signed ops, raw value for unsigned.
  - Latch result sign. mult: sign(a) xor sign(b). div: quotient sign(a) xor sign(b), remainder sign(a).
  - Load counter = WIDTH; go to RUN.
- Divide by zero: start with op[1] = 1 and b == 0 goes to FIX with a zero flag set. No iterations run.
- RUN: one iteration per cycle; counter decrements; after the WIDTH-th iteration go to FIX.
  - Multiply: shift-add over a 2·WIDTH accumulator.
  - Divide: restoring shift-subtract, one quotient bit per cycle.
- FIX:
  - Apply sign correction (negate product / quotient / remainder as latched).
  - Write HI/LO; assert done. Assert div_by_zero instead of writing when the zero flag is set (HI/LO unchanged).
  - Return to IDLE.
- Arithmetic rules:
  - Product is the full 2·WIDTH result; HI gets the upper half.
  - Quotient truncates toward zero; remainder takes the dividend's sign.
  - Signed MIN / −1 gives LO = MIN, HI = 0 (natural modulo result, no trap).
- start outside IDLE is ignored; there is no queueing.
- hi_wr / lo_wr:
  - Honoured only in IDLE; ignored while busy.
  - If coincident with an accepted start, the write happens now and the later result overwrites it.
- Reset (asynchronous, any state): state IDLE, HI = LO = 0, busy = done = div_by_zero = 0, counter = 0. A partial result is discarded.

## Timing
- Accepting edge E0: start sampled high in IDLE. busy goes high after E0.
- Normal op:
  - Iterations on edges E1..E_WIDTH.
  - FIX edge E_{WIDTH+1} updates HI/LO, raises done for one cycle and drops busy.
  - Latency from accepting edge to done visible: WIDTH+1 cycles (33 for WIDTH = 32).
- Divide by zero: FIX on E1; done and div_by_zero high for the cycle after E1.
- Back-to-back: start may be high in the cycle done is high (state is already IDLE); it is accepted.
- Outputs are registered; hi_out/lo_out change only at the FIX edge, hi_wr/lo_wr edges, or reset.

## Configuration
- MULDIV_ABORT_EN defined:
  - abort = 1 in RUN or FIX returns to IDLE at the next edge.
  - HI/LO unchanged; no done or div_by_zero pulse.
  - Used for exception flush.
  - abort in IDLE has no effect; abort coincident with start in IDLE: start wins.
- MULDIV_ABORT_EN undefined: the abort port exists but is ignored; operations always complete.

## Test plan
WIDTH = 32 unless stated.
- mult a = 0xFFFFFFFD (−3), b = 7 -> done at E33; HI = 0xFFFFFFFF, LO = 0xFFFFFFEB; busy high E1–E33.
- multu a = 0xFFFFFFFF, b = 2 -> HI = 0x00000001, LO = 0xFFFFFFFE.
- Division pair:
  - div a = −7, b = 2 -> LO = 0xFFFFFFFD, HI = 0xFFFFFFFF.
  - divu a = 7, b = 2 -> LO = 3, HI = 1.
  - div a = 0x80000000, b = 0xFFFFFFFF -> LO = 0x80000000, HI = 0.
- Preload via hi_wr = 0x1234, lo_wr = 0x5678, then div a = 5, b = 0 -> done and div_by_zero high one cycle after E1; HI = 0x1234, LO = 0x5678 retained.
- Start ignored / reset mid-operation:
  - start pulsed at E5 during a mult -> ignored.
  - Second start in the done cycle -> accepted.
  - reset low at E10 of a mult -> busy = 0, HI = LO = 0 immediately, no done.
- WIDTH = 8 build: mult 0x81 × 0x02 -> HI = 0xFF, LO = 0x02, done at E9.
  - With MULDIV_ABORT_EN: abort at E4 -> idle at E5, HI/LO unchanged, no done.
